// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: holds ALU result, flags and mem/wb control, commits {N,V,C,Z}.
// Optional macro EXMEM_SKID_EN turns the single entry into a head+skid pair (no out_ready->in_ready path).
module ex_mem_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  input  logic                  flag_we,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DATA_W-1:0]     store_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [3:0]            status_flags,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd_addr,
  output logic [DATA_W-1:0]     fwd_result
);

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  flag_we;
    logic                  n;
    logic                  v;
    logic                  c;
    logic                  z;
  } ent_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t     r_state, w_state_nxt;
  ent_t       w_in, r_head;
  logic [3:0] r_status;
  logic       w_accept, w_commit, w_ld_head_in;
`ifdef EXMEM_SKID_EN
  ent_t       r_skid;
  logic       w_ld_head_skid, w_ld_skid;
`endif

  assign w_in = '{result: alu_result, store_data: store_data, rd_addr: rd_addr,
                  reg_write: reg_write, mem_read: mem_read, mem_write: mem_write,
                  flag_we: flag_we, n: alu_result[DATA_W-1], v: alu_overflow,
                  c: alu_carry, z: alu_zero};

  assign out_valid = (r_state != S_EMPTY);
  assign w_commit  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_head_in = 1'b0;
`ifdef EXMEM_SKID_EN
    w_ld_head_skid = 1'b0;
    w_ld_skid      = 1'b0;
    in_ready = (r_state != S_FULL) & ~flush & ~rst;
    w_accept = in_valid & in_ready;
    case (r_state)
      S_EMPTY: if (w_accept) begin w_state_nxt = S_ONE; w_ld_head_in = 1'b1; end
      S_ONE: begin
        if (w_accept && w_commit) w_ld_head_in = 1'b1;
        else if (w_accept) begin w_ld_skid = 1'b1; w_state_nxt = S_FULL; end
        else if (w_commit) w_state_nxt = S_EMPTY;
      end
      // skid drains into head; in_ready is low so nothing new arrives
      S_FULL: if (w_commit) begin w_ld_head_skid = 1'b1; w_state_nxt = S_ONE; end
      default: w_state_nxt = S_EMPTY;
    endcase
`else
    in_ready = (~out_valid | out_ready) & ~flush & ~rst;
    w_accept = in_valid & in_ready;
    w_ld_head_in = w_accept;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
      S_ONE:   if (!w_accept && w_commit) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
`endif
    if (flush) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_status <= 4'b0000;
`ifdef EXMEM_SKID_EN
      r_skid   <= '0;
`endif
    end else begin
      if (w_ld_head_in) r_head <= w_in;
`ifdef EXMEM_SKID_EN
      if (w_ld_head_skid) r_head <= r_skid;
      if (w_ld_skid)      r_skid <= w_in;
`endif
      // a commit coinciding with flush still retires the head
      if (w_commit && r_head.flag_we) r_status <= {r_head.n, r_head.v, r_head.c, r_head.z};
    end
  end

  assign out_result     = r_head.result;
  assign out_store_data = r_head.store_data;
  assign out_rd_addr    = r_head.rd_addr;
  assign out_reg_write  = r_head.reg_write;
  assign out_mem_read   = r_head.mem_read;
  assign out_mem_write  = r_head.mem_write;
  assign status_flags   = r_status;
  assign fwd_valid      = out_valid & out_reg_write & ~out_mem_read;
  assign fwd_rd_addr    = out_rd_addr;
  assign fwd_result     = out_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed steps plus random traffic vs a queue model.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] alu_result, store_data;
  logic        alu_zero, alu_carry, alu_overflow, flag_we;
  logic [2:0]  rd_addr;
  logic        reg_write, mem_read, mem_write, flush;
  logic        out_valid, out_ready;
  logic [15:0] out_result, out_store_data;
  logic [2:0]  out_rd_addr;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic [3:0]  status_flags;
  logic        fwd_valid;
  logic [2:0]  fwd_rd_addr;
  logic [15:0] fwd_result;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .flag_we(flag_we), .rd_addr(rd_addr),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .store_data(store_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_store_data(out_store_data),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .status_flags(status_flags), .fwd_valid(fwd_valid),
    .fwd_rd_addr(fwd_rd_addr), .fwd_result(fwd_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res, sd;
    logic [2:0]  rd;
    logic        rw, mr, mw, fwe;
    logic [3:0]  nvcz;
  } mdl_t;

  mdl_t       q[$];
  logic [3:0] m_status = 4'h0;
  logic       m_rdy;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [15:0] r, input logic vf, input logic cf,
                      input logic zf, input logic fwe, input logic [2:0] rd,
                      input logic rw, input logic mr, input logic mw, input logic [15:0] sd);
    in_valid = v; alu_result = r; alu_overflow = vf; alu_carry = cf; alu_zero = zf;
    flag_we = fwe; rd_addr = rd; reg_write = rw; mem_read = mr; mem_write = mw; store_data = sd;
  endtask

  // Compare all outputs to the model shortly after the falling edge.
  task automatic settle();
    #1;
`ifdef EXMEM_SKID_EN
    m_rdy = !flush && !rst && (q.size() < 2);
`else
    m_rdy = !flush && !rst && (q.size() == 0 || out_ready);
`endif
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("status", 32'(status_flags), 32'(m_status));
    if (q.size() != 0) begin
      chk("out_result", 32'(out_result), 32'(q[0].res));
      chk("out_store_data", 32'(out_store_data), 32'(q[0].sd));
      chk("out_rd_addr", 32'(out_rd_addr), 32'(q[0].rd));
      chk("out_ctl", 32'({out_reg_write, out_mem_read, out_mem_write}),
          32'({q[0].rw, q[0].mr, q[0].mw}));
      chk("fwd_valid", 32'(fwd_valid), 32'(q[0].rw && !q[0].mr));
      chk("fwd_rd_addr", 32'(fwd_rd_addr), 32'(q[0].rd));
      chk("fwd_result", 32'(fwd_result), 32'(q[0].res));
    end else begin
      chk("fwd_valid_idle", 32'(fwd_valid), 32'h0);
    end
  endtask

  // Advance one clock, applying the transfer rules to the model.
  task automatic tick();
    mdl_t e;
    logic acc, com;
    @(posedge clk);
    acc = in_valid && m_rdy;
    com = (q.size() != 0) && out_ready;
    if (com) begin
      if (q[0].fwe) m_status = q[0].nvcz;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (acc) begin
      e.res = alu_result; e.sd = store_data; e.rd = rd_addr;
      e.rw = reg_write; e.mr = mem_read; e.mw = mem_write; e.fwe = flag_we;
      e.nvcz = {alu_result[15], alu_overflow, alu_carry, alu_zero};
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    beat(0, 16'h0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 16'h0);
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_result", 32'(out_result), 32'h0);
    chk("rst_status", 32'(status_flags), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // overflow commit
    out_ready = 1'b1;
    beat(1, 16'h8000, 1, 0, 0, 1, 3'd1, 1, 0, 0, 16'h0);
    step();
    in_valid = 1'b0;
    step();
    settle();
    chk("ovf_status", 32'(status_flags), 32'hC);
    tick();

    // forwarding and load
    beat(1, 16'h00FF, 0, 0, 0, 0, 3'd3, 1, 0, 0, 16'h0);
    step();
    in_valid = 1'b0;
    settle();
    chk("fwd_v", 32'(fwd_valid), 32'h1);
    chk("fwd_rd", 32'(fwd_rd_addr), 32'h3);
    chk("fwd_res", 32'(fwd_result), 32'hFF);
    tick();
    beat(1, 16'h00FF, 0, 0, 0, 0, 3'd3, 1, 1, 0, 16'h0);
    step();
    in_valid = 1'b0;
    settle();
    chk("fwd_load", 32'(fwd_valid), 32'h0);
    tick();

    // backpressure
    out_ready = 1'b0;
    beat(1, 16'h0001, 0, 0, 0, 0, 3'd2, 1, 0, 0, 16'h0);
    step();
    beat(1, 16'h0002, 0, 0, 0, 0, 3'd2, 1, 0, 0, 16'h0);
    settle();
`ifdef EXMEM_SKID_EN
    chk("bp_b_accept", 32'(in_ready), 32'h1);
    chk("bp_hold", 32'(out_result), 32'h1);
    tick();
    in_valid = 1'b0;
    settle();
    chk("bp_full_rdy", 32'(in_ready), 32'h0);
    chk("bp_hold2", 32'(out_result), 32'h1);
    tick();
    out_ready = 1'b1;
    settle();
    chk("bp_first", 32'(out_result), 32'h1);
    tick();
    settle();
    chk("bp_second", 32'(out_result), 32'h2);
    tick();
`else
    chk("bp_b_stall", 32'(in_ready), 32'h0);
    chk("bp_hold", 32'(out_result), 32'h1);
    tick();
    settle();
    chk("bp_hold2", 32'(out_result), 32'h1);
    tick();
    out_ready = 1'b1;
    settle();
    chk("bp_first", 32'(out_result), 32'h1);
    tick();
    in_valid = 1'b0;
    settle();
    chk("bp_second", 32'(out_result), 32'h2);
    tick();
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();

    // flush with a held flag-writing beat
    out_ready = 1'b0;
    beat(1, 16'h0000, 0, 0, 1, 1, 3'd4, 0, 0, 0, 16'h0);
    step();
    beat(1, 16'h5555, 0, 0, 0, 1, 3'd5, 1, 0, 0, 16'h0);
    flush = 1'b1;
    settle();
    chk("flush_rdy", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    settle();
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_status", 32'(status_flags), 32'hC);
    tick();

    // asynchronous reset mid-stream
    beat(1, 16'h1234, 0, 0, 0, 0, 3'd6, 1, 0, 0, 16'h0);
    step();
    in_valid = 1'b0;
    settle();
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_result", 32'(out_result), 32'h0);
    chk("arst_status", 32'(status_flags), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h0);
    q.delete();
    m_status = 4'h0;
    #1 rst = 1'b0;
    tick();
    out_ready = 1'b1;
    beat(1, 16'h4321, 0, 0, 0, 0, 3'd7, 1, 0, 0, 16'h0);
    step();
    in_valid = 1'b0;
    settle();
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    chk("post_rst_result", 32'(out_result), 32'h4321);
    tick();

    // full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(1, 16'h0100 + 16'(i), 0, 0, 0, 0, 3'(i), 1, 0, 0, 16'h0);
      settle();
      if (i > 0) begin
        chk("tput_valid", 32'(out_valid), 32'h1);
        chk("tput_order", 32'(out_result), 32'h0100 + 32'(i - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    settle();
    chk("tput_last", 32'(out_result), 32'h0107);
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      beat(1'($urandom_range(0, 9) < 7), 16'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 16'($urandom));
      out_ready = 1'($urandom_range(0, 9) < 6);
      flush = 1'($urandom_range(0, 19) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register directly downstream of the 16-bit ALU. It captures the ALU result, the ALU flags and the memory/writeback control of one instruction per beat, and presents them to the memory stage over a valid/ready handshake. It holds the architectural status register {N,V,C,Z}, which is updated only when an instruction commits out of the stage. It also exposes a forwarding tap back to operand selection.

## Interface
- DATA_W, 16, datapath width (ALU result, store data)
- REG_ADDR_W, 3, destination register index width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage offers a beat
- in_ready  out  1  stage accepts the beat this cycle
- alu_result  in  DATA_W  ALU result
- alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags for this beat
- flag_we  in  1  instruction updates status on commit
- rd_addr  in  REG_ADDR_W  destination register
- reg_write, mem_read, mem_write  in  1 each  downstream control
- store_data  in  DATA_W  rs2 value for stores
- flush  in  1  discard all held and incoming beats
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage accepts the head entry
- out_result, out_store_data  out  DATA_W  head entry data
- out_rd_addr  out  REG_ADDR_W  head entry destination
- out_reg_write, out_mem_read, out_mem_write  out  1 each  head entry control
- status_flags  out  4  committed {N,V,C,Z}
- fwd_valid  out  1  out_valid & out_reg_write & ~out_mem_read
- fwd_rd_addr, fwd_result  out  REG_ADDR_W / DATA_W  equal to out_rd_addr and out_result
- Clock/reset fixed: one clock, clk; reset rst is asynchronous and active-high.

## Operation
- Accept: in_valid & in_ready. Commit: out_valid & out_ready.
- An entry stores result, store_data, rd_addr, the three control bits, flag_we, N = alu_result[DATA_W-1], V, C and Z.
- Commit with stored flag_we=1: status_flags <= {N,V,C,Z} of the head entry. Any other cycle: status_flags holds its value.
- Flush:
  - All entries are invalidated at the next edge.
  - in_ready is forced to 0 in a flush cycle, so the incoming beat is dropped.
  - A commit in the same cycle still updates status_flags.
  - Flushed entries never affect status_flags.
- Entries leave in acceptance order. Data does not change while out_valid=1 and out_ready=0.
- Reset, asynchronous: all entries invalid, every out_* = 0, fwd_* = 0, status_flags = 4'b0000, in_ready = 0 while rst=1.

## Timing
- Latency: accept at edge k, then out_valid=1 in cycle k+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Default build is a single entry:
  - States EMPTY and ONE.
  - in_ready = (~out_valid | out_ready) & ~flush & ~rst. This is a combinational path from out_ready.
  - EMPTY→ONE on accept.
  - ONE→ONE on accept+commit.
  - ONE→EMPTY on commit without accept.
- flush from any state → EMPTY at the next edge.

## Configuration
- EXMEM_SKID_EN defined: two-entry skid buffer (head plus skid). There is no combinational path from out_ready to in_ready.
- States EMPTY, ONE, FULL. in_ready = (state≠FULL) & ~flush & ~rst.
- EMPTY→ONE on accept.
- ONE→ONE on accept+commit.
- ONE→EMPTY on commit only.
- ONE→FULL on accept without commit; the beat goes to skid.
- FULL→ONE on commit; skid moves to head and no accept is possible.
- FULL holds while out_ready=0.
- Not defined: single-entry behaviour as in Timing.

## Test plan
- Reset mid-stream:
  - Stimulus: rst pulsed asynchronously while ONE holds result 0x1234.
  - Response: out_valid=0, out_result=0, status_flags=0 immediately; first beat after release appears one cycle after accept.
- Overflow commit:
  - Stimulus: beat alu_result=0x8000, V=1, C=0, Z=0, flag_we=1, out_ready=1.
  - Response: status_flags=4'b1100 one cycle after commit.
- Backpressure:
  - Stimulus: out_ready=0, beats A=0x0001 and B=0x0002 offered back-to-back.
  - Response, default build: B stalls (in_ready=0) and out_result holds 0x0001.
  - Response, EXMEM_SKID_EN: B accepted, FULL, in_ready=0, and after out_ready=1 the outputs are 0x0001 then 0x0002.
- Flush:
  - Stimulus: flush=1 with one held beat (flag_we=1, Z=1) and in_valid=1, out_ready=0.
  - Response: out_valid=0 next cycle, status_flags unchanged, incoming beat not accepted.
- Forwarding and load:
  - Stimulus: committed beat rd=3, reg_write=1, result 0x00FF.
  - Response: fwd_valid=1, fwd_rd_addr=3, fwd_result=0x00FF.
  - Stimulus: same beat with mem_read=1.
  - Response: fwd_valid=0.
- Full throughput:
  - Stimulus: 8 consecutive beats, out_ready=1.
  - Response: 8 consecutive out_valid cycles, order preserved, no bubble.
